// File: rtl/fp_add_seq_pkg.sv
// Shared types and constants for the sequential single-precision adder.
// Latency: n/a (declarations and a combinational unpack helper only).
// Backpressure: n/a.
package fp_add_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ALIGN,
        ADD,
        NORM,
        DONE
    } state_t;

    localparam int          EXP_MAX     = 255;
    localparam logic [31:0] QNAN        = 32'h7FC0_0000;
    localparam logic [4:0]  LZC_ALLZERO = 5'd31;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [23:0] mant;     // hidden bit included; zero when flushed
        logic        is_zero;  // exp==0: zeros and denormals alike
        logic        is_inf;
        logic        is_nan;
    } fp_unpk_t;

    function automatic fp_unpk_t unpack(input logic [31:0] v);
        fp_unpk_t u;
        u.sign    = v[31];
        u.exp     = v[30:23];
        u.is_zero = (v[30:23] == 8'h00);
        u.is_inf  = (v[30:23] == 8'hFF) && (v[22:0] == 23'd0);
        u.is_nan  = (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
        u.mant    = u.is_zero ? 24'd0 : {1'b1, v[22:0]};
        return u;
    endfunction

endpackage

// File: rtl/fp_add_seq_if.sv
// Operand/result handshake bundle for fp_add_seq.
// Latency: n/a (wires only).
// Backpressure: in_valid/in_ready on operands, out_valid/out_ready on the sum.
// master: operand source + result consumer; slave: the adder.
interface fp_add_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, sum
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, sum
    );
endinterface

// File: rtl/encoder_25x5.sv
// Leading-zero count of a 25-bit word; 31 means the word is all zero.
// Latency: combinational.
// Backpressure: none.
// Ports: din (25-bit word), lz (count of zeros above the most significant one).
module encoder_25x5
    import fp_add_seq_pkg::*;
(
    input  logic [24:0] din,
    output logic [4:0]  lz
);

    // Ascending scan: the highest set bit is the last one to write lz.
    always_comb begin
        lz = LZC_ALLZERO;
        for (int i = 0; i < 25; i++) begin
            if (din[i]) begin
                lz = 5'(24 - i);
            end
        end
    end

endmodule

// File: rtl/fp_add_seq.sv
// Sequential IEEE-754 single add: IDLE -> ALIGN -> ADD -> NORM -> DONE, truncating rounding.
// Latency: sum presented 4 edges after the accept edge; at most one operation every 5 cycles.
// Backpressure: in_ready only in IDLE; sum/out_valid held in DONE until out_ready.
// Ports: clk, rst (sync, active high), io (slave handshake bundle), busy (not IDLE),
//        op_count (handed-off results, wraps).
module fp_add_seq
    import fp_add_seq_pkg::*;
#(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    fp_add_seq_if.slave      io,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    localparam int MANT_W = FRAC_W + 1;
    localparam int RES_W  = FRAC_W + 2;
    localparam logic signed [EXP_W+1:0] E_MAX = (EXP_W + 2)'(EXP_MAX);

    state_t              state_q, state_d;
    logic [31:0]         a_q, b_q;
    logic [MANT_W-1:0]   ml_q, ms_q;
    logic [EXP_W-1:0]    expl_q;
    logic                sign_q, sub_q, spec_q;
    logic [31:0]         spec_val_q;
    logic [RES_W-1:0]    res_q;
    logic [31:0]         sum_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [4:0]          lz;

    // ---------------- ALIGN: unpack, order by magnitude, shift smaller ----------------
    fp_unpk_t            ua, ub;
    logic                a_ge;
    logic                l_sign;
    logic [EXP_W-1:0]    l_exp, s_exp, d;
    logic [MANT_W-1:0]   l_mant, s_mant, ms_al;
    logic                spec_d;
    logic [31:0]         spec_val_d;

    always_comb begin
        ua     = unpack(a_q);
        ub     = unpack(b_q);
        // {exp, mant} orders magnitudes because mant carries the hidden bit.
        a_ge   = {ua.exp, ua.mant} >= {ub.exp, ub.mant};
        l_sign = a_ge ? ua.sign : ub.sign;
        l_exp  = a_ge ? ua.exp  : ub.exp;
        l_mant = a_ge ? ua.mant : ub.mant;
        s_exp  = a_ge ? ub.exp  : ua.exp;
        s_mant = a_ge ? ub.mant : ua.mant;
        d      = l_exp - s_exp;
        ms_al  = (d >= 8'd25) ? '0 : (s_mant >> d);

        spec_d     = 1'b1;
        spec_val_d = '0;
        if (ua.is_nan || ub.is_nan || (ua.is_inf && ub.is_inf && (ua.sign != ub.sign))) begin
            spec_val_d = QNAN;
        end else if (ua.is_inf) begin
            spec_val_d = {ua.sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
        end else if (ub.is_inf) begin
            spec_val_d = {ub.sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
        end else if (ua.is_zero && ub.is_zero) begin
            spec_val_d = {ua.sign & ub.sign, 31'd0};
        end else begin
            spec_d = 1'b0;
        end
    end

    // ---------------- NORM: renormalise the ADD result ----------------
    encoder_25x5 u_lzc (
        .din (res_q),
        .lz  (lz)
    );

    logic signed [EXP_W+1:0] e_n;
    logic [FRAC_W-1:0]       frac_n;
    logic [31:0]             norm_sum;

    always_comb begin
        e_n      = '0;
        frac_n   = '0;
        norm_sum = '0;
        if (spec_q) begin
            norm_sum = spec_val_q;
        end else if (lz == LZC_ALLZERO) begin
            norm_sum = '0;      // exact cancellation is always +0
        end else begin
            if (lz == 5'd0) begin
                // carry out of the hidden-bit position
                frac_n = res_q[FRAC_W:1];
                e_n    = $signed({2'b00, expl_q} + {{(EXP_W + 1){1'b0}}, 1'b1});
            end else begin
                frac_n = FRAC_W'(res_q << (lz - 5'd1));
                e_n    = $signed({2'b00, expl_q} - {{(EXP_W - 3){1'b0}}, lz - 5'd1});
            end
            if (e_n >= E_MAX) begin
                norm_sum = {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
            end else if (e_n[EXP_W+1] || (e_n == '0)) begin
                norm_sum = {sign_q, 31'd0};
            end else begin
                norm_sum = {sign_q, e_n[EXP_W-1:0], frac_n};
            end
        end
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (io.in_valid)  state_d = ALIGN;
            ALIGN:   state_d = ADD;
            ADD:     state_d = NORM;
            NORM:    state_d = DONE;
            DONE:    if (io.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q        <= '0;
            b_q        <= '0;
            ml_q       <= '0;
            ms_q       <= '0;
            expl_q     <= '0;
            sign_q     <= 1'b0;
            sub_q      <= 1'b0;
            spec_q     <= 1'b0;
            spec_val_q <= '0;
            res_q      <= '0;
            sum_q      <= '0;
            cnt_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (io.in_valid) begin
                        a_q <= io.a;
                        b_q <= io.b;
                    end
                end
                ALIGN: begin
                    ml_q       <= l_mant;
                    ms_q       <= ms_al;
                    expl_q     <= l_exp;
                    sign_q     <= l_sign;
                    sub_q      <= ua.sign ^ ub.sign;
                    spec_q     <= spec_d;
                    spec_val_q <= spec_val_d;
                end
                ADD: begin
                    // Swap guarantees ml >= ms, so the difference never goes negative.
                    res_q <= sub_q ? ({1'b0, ml_q} - {1'b0, ms_q})
                                   : ({1'b0, ml_q} + {1'b0, ms_q});
                end
                NORM: begin
                    sum_q <= norm_sum;
                end
                DONE: begin
                    if (io.out_ready) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign io.in_ready  = (state_q == IDLE);
    assign io.out_valid = (state_q == DONE);
    assign io.sum       = sum_q;
    assign busy         = (state_q != IDLE);
    assign op_count     = cnt_q;

endmodule

// File: tb/tb_fp_add_seq.sv
// Scoreboard bench for fp_add_seq: directed corner vectors, hold/backpressure,
// mid-operation reset and random operands checked against a value-level model.
module tb_fp_add_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        busy;
    logic [15:0] op_count;

    fp_add_seq_if bus ();

    fp_add_seq #(.EXP_W(8), .FRAC_W(23), .CNT_W(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .io       (bus),
        .busy     (busy),
        .op_count (op_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;
    int ready_mode = 0;     // 0: out_ready high, 1: random, 2: held low
    int cnt_model = 0;

    typedef struct {
        logic [31:0] val;
        int          acc;   // edge on which the operands were accepted
        bit          lat;   // latency is checkable (consumer always ready)
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] s;
    } vec_t;
    vec_t dir [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Value-level reference: flush denormals, truncate the smaller operand to the
    // larger one's scale, add/subtract exactly, then renormalise by locating the MSB.
    function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
        int ea, eb, el, es, p, e;
        longint ma, mb, ml, ms, r;
        logic sl, na, nb, ia, ib;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        na = (ea == 255) && (a[22:0] != 0);
        nb = (eb == 255) && (b[22:0] != 0);
        ia = (ea == 255) && (a[22:0] == 0);
        ib = (eb == 255) && (b[22:0] == 0);
        if (na || nb || (ia && ib && (a[31] != b[31]))) return 32'h7FC00000;
        if (ia) return a;
        if (ib) return b;
        if (ea == 0 && eb == 0) return {a[31] & b[31], 31'd0};
        ma = (ea == 0) ? 0 : (longint'(a[22:0]) + 64'h800000);
        mb = (eb == 0) ? 0 : (longint'(b[22:0]) + 64'h800000);
        if ((longint'(ea) * 16777216 + ma) >= (longint'(eb) * 16777216 + mb)) begin
            sl = a[31]; el = ea; es = eb; ml = ma; ms = mb;
        end else begin
            sl = b[31]; el = eb; es = ea; ml = mb; ms = ma;
        end
        if (el - es >= 25) ms = 0;
        else ms = ms >> (el - es);
        r = (a[31] == b[31]) ? ml + ms : ml - ms;
        if (r == 0) return 32'h0;
        p = 0;
        while ((r >> (p + 1)) != 0) p++;
        e = el + p - 23;
        if (p >= 23) r = r >> (p - 23);
        else r = r << (23 - p);
        if (e >= 255) return {sl, 8'hFF, 23'd0};
        if (e <= 0) return {sl, 31'd0};
        return {sl, 8'(e), r[22:0]};
    endfunction

    function automatic logic [31:0] rand_op(input logic [31:0] near);
        logic [31:0] v;
        int k, e;
        v = $urandom;
        k = $urandom_range(0, 15);
        if (k == 0) begin
            v[30:23] = 8'hFF;
            if ($urandom_range(0, 1) == 1) v[22:0] = '0;
        end else if (k == 1) begin
            v[30:23] = 8'h00;
        end else if (k <= 8) begin
            e = int'(near[30:23]) + int'($urandom_range(0, 4)) - 2;
            if (e < 1) e = 1;
            if (e > 254) e = 254;
            v[30:23] = 8'(e);
            if (k == 2) v[22:0] = near[22:0] ^ 23'($urandom_range(0, 15));
        end else if (k <= 10) begin
            e = int'(near[30:23]) - 23 - int'($urandom_range(0, 3));
            if (e < 1) e = 1;
            v[30:23] = 8'(e);
        end else begin
            v[30:23] = 8'($urandom_range(1, 254));
        end
        return v;
    endfunction

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [31:0] expv);
        int n;
        n = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.a = a;
        bus.b = b;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready stuck at %b, expected 1", bus.in_ready);
            bus.in_valid = 1'b0;
            return;
        end
        sbq.push_back('{val: expv, acc: cyc + 1, lat: (ready_mode == 0)});
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sbq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", sbq.size());
            sbq.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    // Monitor: drives out_ready, checks hold stability and pops the scoreboard.
    initial begin
        logic [31:0] prev_sum;
        bit hold;
        exp_t e;
        hold = 0;
        prev_sum = '0;
        forever begin
            @(negedge clk);
            case (ready_mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = ($urandom_range(0, 2) != 0);
                default: bus.out_ready = 1'b0;
            endcase
            if (rst) begin
                hold = 0;
                continue;
            end
            if (hold) begin
                chk("hold_valid", bus.out_valid, 1);
                chk("hold_sum", bus.sum, prev_sum);
            end
            if (bus.out_valid) chk("in_ready_in_done", bus.in_ready, 0);
            if (bus.out_valid && bus.out_ready) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: sum %h, expected no output", bus.sum);
                end else begin
                    e = sbq.pop_front();
                    chk("sum", bus.sum, e.val);
                    chk("op_count", op_count, cnt_model);
                    if (e.lat) chk("latency", cyc + 1 - e.acc, 4);
                    cnt_model++;
                end
            end
            hold = bus.out_valid && !bus.out_ready;
            prev_sum = bus.sum;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra, rb;
        int n;
        bus.in_valid = 1'b0;
        bus.a = '0;
        bus.b = '0;
        dir = '{
            '{32'h3F800000, 32'h3F800000, 32'h40000000},
            '{32'h3FC00000, 32'hBF800000, 32'h3F000000},
            '{32'h3F800000, 32'hBF800000, 32'h00000000},
            '{32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000},
            '{32'h7F800000, 32'hFF800000, 32'h7FC00000},
            '{32'h7FC00001, 32'h3F800000, 32'h7FC00000},
            '{32'h3F800000, 32'h33800000, 32'h3F800000},
            '{32'h3F800000, 32'h33000000, 32'h3F800000},
            '{32'h80000000, 32'h80000000, 32'h80000000},
            '{32'h80000000, 32'h00000000, 32'h00000000},
            '{32'hFF800000, 32'h3F800000, 32'hFF800000},
            '{32'h00000001, 32'h80000002, 32'h00000000},
            '{32'h40400000, 32'hBF800000, 32'h40000000},
            '{32'h7F800000, 32'h7F800000, 32'h7F800000},
            '{32'h00800001, 32'h80800000, 32'h00000000}
        };

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_op_count", op_count, 0);
        chk("rst_sum", bus.sum, 0);
        rst = 1'b0;

        // directed corners, consumer always ready
        ready_mode = 0;
        foreach (dir[i]) send(dir[i].a, dir[i].b, dir[i].s);
        drain();
        chk("op_count_directed", op_count, cnt_model);

        // hold in DONE for several cycles with a new operand pair waiting
        @(posedge clk);
        #1 ready_mode = 2;
        send(32'h3FC00000, 32'h3F800000, 32'h40200000);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.a = 32'h40000000;
        bus.b = 32'h40000000;
        n = 0;
        while (!bus.out_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("hold_reached_done", bus.out_valid, 1);
        repeat (3) begin
            @(negedge clk);
            chk("hold_in_ready", bus.in_ready, 0);
            chk("hold_busy", busy, 1);
        end
        @(posedge clk);
        #1 ready_mode = 0;
        send(32'h40000000, 32'h40000000, 32'h40800000);
        drain();

        // reset while in ADD drops the operation
        send(32'h3F800000, 32'h40000000, 32'h40400000);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        sbq.delete();
        @(posedge clk);
        @(negedge clk);
        chk("midrst_in_ready", bus.in_ready, 1);
        chk("midrst_out_valid", bus.out_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_op_count", op_count, 0);
        cnt_model = 0;
        rst = 1'b0;
        repeat (8) begin
            @(negedge clk);
            chk("midrst_no_stale", bus.out_valid, 0);
        end
        send(32'h3F800000, 32'h40000000, 32'h40400000);
        drain();

        // random operands with a randomly stalling consumer
        @(posedge clk);
        #1 ready_mode = 1;
        repeat (80) begin
            ra = rand_op($urandom);
            rb = rand_op(ra);
            send(ra, rb, ref_add(ra, rb));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        drain();
        chk("op_count_final", op_count, cnt_model);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
